// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencing for the five-stage pipeline.
// Chooses the next PC source and the PC / IF-ID write enables.
// Handles load-use stalls, instruction-memory waits, branch/jump redirects and halt/resume.
// Also keeps saturating stall and flush counters.
module if_fetch_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic [1:0]       pcsource,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_VEC = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             hazard;
    logic             stall_inc, flush_inc;

    // A load in EX feeding a register read in ID; r0 never creates a dependency.
    assign hazard = ex_wreg && ex_m2reg && (ex_rd != '0) &&
                    ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

    // Control outputs and next state, decided from the current state and the live inputs.
    always_comb begin
        pcsource    = PC_SEQ;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (clrn) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = BOOT;
        end else begin
            case (state_q)
                BOOT: begin
                    pcsource   = PC_VEC;
                    pc_we      = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = halt_req ? HALT : RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        state_d     = HALT;
                    end else if (hazard) begin
                        // Branch operands are stale this cycle, so any redirect waits.
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (!imem_ready) begin
                        // ID stays frozen, so a pending redirect is seen again next cycle.
                        stall_inc = 1'b1;
                    end else if (id_jump) begin
                        pcsource   = PC_JMP;
                        pc_we      = 1'b1;
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (id_branch) begin
                        pcsource   = PC_BR;
                        pc_we      = 1'b1;
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                    end
                end
                HALT: begin
                    idex_bubble = 1'b1;
                    if (!halt_req) state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign halted    = !clrn && (state_q == HALT);
    assign stall_d   = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    assign flush_d   = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    // State and saturating counters; reset drops everything back to BOOT.
    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q <= BOOT;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus randomized traffic.
// Stimulus is checked against a cycle-level reference model.
// Two instances share stimulus: 16-bit counters and 4-bit counters (for saturation).
module tb_if_fetch_ctrl;

    logic       clk;
    logic       clrn;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_wreg, ex_m2reg;
    logic       id_branch, id_jump, imem_ready, halt_req;

    logic [1:0]  pcsource, pcsource4;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, halted;
    logic        pc_we4, ifid_we4, ifid_flush4, idex_bubble4, halted4;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit m_boot, m_halt;
    int m_stall, m_flush;
    // expected values for the current cycle
    logic [1:0] e_pcs;
    logic e_pcwe, e_ifwe, e_fl, e_bub, e_halt, e_stall;

    if_fetch_ctrl #(.REG_W(5), .CNT_W(16)) u16 (
        .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg), .ex_rd(ex_rd), .id_branch(id_branch), .id_jump(id_jump),
        .imem_ready(imem_ready), .halt_req(halt_req), .pcsource(pcsource), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    if_fetch_ctrl #(.REG_W(5), .CNT_W(4)) u4 (
        .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg), .ex_rd(ex_rd), .id_branch(id_branch), .id_jump(id_jump),
        .imem_ready(imem_ready), .halt_req(halt_req), .pcsource(pcsource4), .pc_we(pc_we4),
        .ifid_we(ifid_we4), .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
        .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic set_idle();
        clrn = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_wreg = 0; ex_m2reg = 0;
        id_branch = 0; id_jump = 0; imem_ready = 1; halt_req = 0;
    endtask

    // Settle to the falling edge and derive what the outputs must be this cycle.
    task automatic eval();
        bit load_use, frozen;
        @(negedge clk);
        load_use = ex_wreg && ex_m2reg && (ex_rd != 0) &&
                   ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
        e_pcs = 0; e_pcwe = 0; e_ifwe = 0; e_fl = 0; e_bub = 0; e_halt = 0; e_stall = 0;
        if (clrn) begin
            e_fl = 1; e_bub = 1;
        end else if (m_boot) begin
            e_pcs = 3; e_pcwe = 1; e_fl = 1;
        end else if (m_halt) begin
            e_bub = 1; e_halt = 1;
        end else begin
            frozen  = halt_req || load_use || !imem_ready;
            e_stall = frozen;
            e_bub   = halt_req || load_use;
            if (!frozen) begin
                e_pcwe = 1;
                e_pcs  = id_jump ? 2'd2 : (id_branch ? 2'd1 : 2'd0);
                e_fl   = id_jump || id_branch;
                e_ifwe = !(id_jump || id_branch);
            end
        end
    endtask

    // Clock edge: advance the model with this cycle's decisions, then release inputs.
    task automatic tick();
        @(posedge clk);
        if (clrn) begin
            m_boot = 1; m_halt = 0; m_stall = 0; m_flush = 0;
        end else if (m_boot) begin
            m_boot = 0; m_halt = halt_req;
        end else if (m_halt) begin
            m_halt = halt_req;
        end else begin
            if (e_stall) m_stall++;
            if (e_fl) m_flush++;
            m_halt = halt_req;
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        clrn = 1; eval(); tick();
        clrn = 0; eval(); tick();
    endtask

    task automatic test_reset();
        set_idle();
        clrn = 1; eval(); tick();
        eval();
        n_chk++; if (pcsource !== 2'd0 || pc_we !== 1'b0 || ifid_we !== 1'b0) begin
            n_err++; $display("FAIL reset_ctl got pcs=%0d pc_we=%b ifid_we=%b exp 0 0 0", pcsource, pc_we, ifid_we); end
        n_chk++; if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_flush got fl=%b bub=%b halted=%b exp 1 1 0", ifid_flush, idex_bubble, halted); end
        n_chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt); end
        tick();
        clrn = 0; eval();
        n_chk++; if (pcsource !== 2'd3 || pc_we !== 1'b1 || ifid_flush !== 1'b1 || idex_bubble !== 1'b0) begin
            n_err++; $display("FAIL boot got pcs=%0d pc_we=%b fl=%b bub=%b exp 3 1 1 0", pcsource, pc_we, ifid_flush, idex_bubble); end
        tick(); eval();
        n_chk++; if (pcsource !== 2'd0 || pc_we !== 1'b1 || ifid_we !== 1'b1 || ifid_flush !== 1'b0) begin
            n_err++; $display("FAIL run0 got pcs=%0d pc_we=%b ifid_we=%b fl=%b exp 0 1 1 0", pcsource, pc_we, ifid_we, ifid_flush); end
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        ex_wreg = 1; ex_m2reg = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        eval();
        n_chk++; if (pc_we !== 1'b0 || idex_bubble !== 1'b1 || ifid_we !== 1'b0) begin
            n_err++; $display("FAIL hazard_stall got pc_we=%b bub=%b ifid_we=%b exp 0 1 0", pc_we, idex_bubble, ifid_we); end
        tick();
        ex_rd = 0; id_rs = 0;
        eval();
        n_chk++; if (stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL hazard_cnt got %0d exp 1", stall_cnt); end
        n_chk++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
            n_err++; $display("FAIL hazard_r0 got pc_we=%b bub=%b exp 1 0", pc_we, idex_bubble); end
        tick();
        set_idle();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        ex_wreg = 1; ex_m2reg = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1; id_branch = 1;
        eval();
        n_chk++; if (pcsource !== 2'd0 || ifid_flush !== 1'b0 || pc_we !== 1'b0) begin
            n_err++; $display("FAIL br_haz got pcs=%0d fl=%b pc_we=%b exp 0 0 0", pcsource, ifid_flush, pc_we); end
        tick();
        ex_wreg = 0; ex_m2reg = 0;
        eval();
        n_chk++; if (pcsource !== 2'd1 || ifid_flush !== 1'b1 || pc_we !== 1'b1) begin
            n_err++; $display("FAIL br_take got pcs=%0d fl=%b pc_we=%b exp 1 1 1", pcsource, ifid_flush, pc_we); end
        tick();
        id_branch = 0;
        eval();
        n_chk++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
            n_err++; $display("FAIL br_cnt got flush=%0d stall=%0d exp 1 1", flush_cnt, stall_cnt); end
        tick();
        set_idle();
    endtask

    task automatic test_imem_wait();
        do_reset();
        id_jump = 1; id_branch = 1; imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            n_chk++; if (pc_we !== 1'b0 || idex_bubble !== 1'b0 || ifid_flush !== 1'b0) begin
                n_err++; $display("FAIL imem_wait%0d got pc_we=%b bub=%b fl=%b exp 0 0 0", i, pc_we, idex_bubble, ifid_flush); end
            tick();
        end
        imem_ready = 1;
        eval();
        n_chk++; if (pcsource !== 2'd2 || pc_we !== 1'b1 || stall_cnt !== 16'd3) begin
            n_err++; $display("FAIL imem_jump got pcs=%0d pc_we=%b stall=%0d exp 2 1 3", pcsource, pc_we, stall_cnt); end
        tick();
        id_jump = 0; id_branch = 0;
        eval();
        n_chk++; if (flush_cnt !== 16'd1 || pcsource !== 2'd0) begin
            n_err++; $display("FAIL imem_after got flush=%0d pcs=%0d exp 1 0", flush_cnt, pcsource); end
        tick();
        set_idle();
    endtask

    task automatic test_halt();
        int nh;
        do_reset();
        nh = 0;
        halt_req = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) halt_req = 0;
            eval();
            if (halted === 1'b1) nh++;
            n_chk++; if (halted !== e_halt || pc_we !== e_pcwe) begin
                n_err++; $display("FAIL halt_cyc%0d got halted=%b pc_we=%b exp %b %b", i, halted, pc_we, e_halt, e_pcwe); end
            tick();
        end
        eval();
        n_chk++; if (nh != 4) begin
            n_err++; $display("FAIL halt_len got %0d exp 4", nh); end
        n_chk++; if (stall_cnt !== 16'd1 || pc_we !== 1'b1) begin
            n_err++; $display("FAIL halt_resume got stall=%0d pc_we=%b exp 1 1", stall_cnt, pc_we); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        ex_wreg = 1; ex_m2reg = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
        for (int i = 0; i < 20; i++) begin
            eval();
            n_chk++; if (stall_cnt4 !== 4'(sat(i, 4)) || stall_cnt !== 16'(i)) begin
                n_err++; $display("FAIL sat%0d got s4=%0d s16=%0d exp %0d %0d", i, stall_cnt4, stall_cnt, sat(i, 4), i); end
            tick();
        end
        eval();
        n_chk++; if (stall_cnt4 !== 4'd15) begin
            n_err++; $display("FAIL sat_hold got %0d exp 15", stall_cnt4); end
        tick();
        set_idle();
        halt_req = 1;
        eval(); tick(); eval(); tick();
        clrn = 1;
        eval();
        n_chk++; if (halted !== 1'b0 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin
            n_err++; $display("FAIL halt_rst got halted=%b fl=%b bub=%b exp 0 1 1", halted, ifid_flush, idex_bubble); end
        tick();
        clrn = 0; halt_req = 0;
        eval();
        n_chk++; if (pcsource !== 2'd3 || stall_cnt4 !== 4'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_err++; $display("FAIL halt_rst_boot got pcs=%0d s4=%0d s16=%0d f=%0d exp 3 0 0 0", pcsource, stall_cnt4, stall_cnt, flush_cnt); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            clrn       = ($urandom_range(0, 99) == 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            ex_wreg    = 1'($urandom);
            ex_m2reg   = 1'($urandom);
            id_branch  = ($urandom_range(0, 3) == 0);
            id_jump    = ($urandom_range(0, 5) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            halt_req   = halt_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            eval();
            n_chk++; if (pcsource !== e_pcs || pc_we !== e_pcwe || ifid_we !== e_ifwe) begin
                n_err++; $display("FAIL rnd_ctl c%0d got pcs=%0d pc_we=%b ifid_we=%b exp %0d %b %b", c, pcsource, pc_we, ifid_we, e_pcs, e_pcwe, e_ifwe); end
            n_chk++; if (ifid_flush !== e_fl || idex_bubble !== e_bub || halted !== e_halt) begin
                n_err++; $display("FAIL rnd_fl c%0d got fl=%b bub=%b halted=%b exp %b %b %b", c, ifid_flush, idex_bubble, halted, e_fl, e_bub, e_halt); end
            n_chk++; if (stall_cnt !== 16'(sat(m_stall, 16)) || flush_cnt !== 16'(sat(m_flush, 16))) begin
                n_err++; $display("FAIL rnd_cnt16 c%0d got s=%0d f=%0d exp %0d %0d", c, stall_cnt, flush_cnt, sat(m_stall, 16), sat(m_flush, 16)); end
            n_chk++; if (stall_cnt4 !== 4'(sat(m_stall, 4)) || flush_cnt4 !== 4'(sat(m_flush, 4)) || pc_we4 !== e_pcwe) begin
                n_err++; $display("FAIL rnd_cnt4 c%0d got s=%0d f=%0d pc_we=%b exp %0d %0d %b", c, stall_cnt4, flush_cnt4, pc_we4, sat(m_stall, 4), sat(m_flush, 4), e_pcwe); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        clrn = 1;
        m_boot = 1; m_halt = 0; m_stall = 0; m_flush = 0;
        test_reset();
        test_hazard();
        test_branch_hazard();
        test_imem_wait();
        test_halt();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
